pipelined_read_mux: RTL and testbench
=====================================

Name: pipelined_read_mux

Overview:
- Parametrised, pipelined DEPTH:1 word selector. It is the read port behind the register file: selects one WIDTH-bit entry from a flattened DEPTH-entry array.
- Two registered stages with valid/ready flow control.
- Same-cycle write forwarding, plus an optional hard-wired zero entry (X31 convention).
- Sits between the register-file storage array and the datapath operand registers; one instance per read port.

Parameters:
- WIDTH, 64, bits per entry.
- DEPTH, 32, number of entries; must be ≥2 and ≤ BANK*BANK.
- BANK, 16, entries per first-level bank mux; NBANK = ceil(DEPTH/BANK).
- ZERO_REG, 1, when 1 entry DEPTH-1 always reads 0 and is never forwarded.
- SEL_W, $clog2(DEPTH), select width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- data  input  DEPTH*WIDTH  entry k at bits [k*WIDTH +: WIDTH]
- in_valid  input  1  read request present
- in_ready  output  1  request accepted this cycle when in_valid && in_ready
- sel  input  SEL_W  entry index, sampled at acceptance
- wr_en  input  1  concurrent register-file write
- wr_addr  input  SEL_W  write index
- wr_data  input  WIDTH  write data
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  WIDTH  selected word
- out_sel  output  SEL_W  index that produced out_data

Behaviour:
- Reset (async on reset_n=0, released synchronously to clk): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sel=0. in_ready=1 one cycle after release.
- Stage 1 captures on acceptance (in_valid && in_ready):
  - NBANK bank-mux results, each a BANK:1 select of data on sel[log2(BANK)-1:0].
  - Upper select bits, full sel, a zero flag and a forward flag.
- Forward flag = wr_en && wr_addr==sel && !(ZERO_REG && sel==DEPTH-1). When set, the forwarded wr_data (captured) wins over the array value.
- Zero flag = (ZERO_REG && sel==DEPTH-1) || sel≥DEPTH. When set, the result is 0.
- Stage 2: selects the bank by upper bits, applies forward/zero priority (zero > forward > array), and registers into out_data/out_sel.
- Latency: exactly 2 cycles from acceptance to out_valid=1 when out_ready stays high.
- Throughput: 1 request per cycle.
- Snapshot semantics: data and wr_* are sampled only at acceptance. Array changes while a request is in flight are not reflected.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no combinational path from in_valid).
- Stall: while out_valid && !out_ready, out_data/out_sel hold stable, and stage 1 holds if full. The pipeline holds at most 2 requests. No request is dropped or duplicated.
- Simultaneous: out handshake and in acceptance in the same cycle both occur; occupancy is unchanged.
- Wr_addr==sel when wr_en=0: no forward.
- Reset mid-operation: all in-flight requests are discarded and out_valid drops immediately (async).
- BANK must be a power of two. Banks past DEPTH are padded with 0 inputs.

Decomposition:
- Package read_mux_pkg holds:
  - default WIDTH/DEPTH/BANK constants;
  - a typedef for the stage-1 record (bank words, upper sel, sel, zero, fwd, fwd_data);
  - the result-priority enum {RES_ARRAY, RES_FWD, RES_ZERO}.
- One sub-module, bank_mux: a parametrised combinational BANK:1 mux of WIDTH-bit words. It is instantiated NBANK times in stage 1 and reused (NBANK:1) in stage 2.

Test Plan:
- Reset then entry k=k*0x1111, out_ready=1, sel=5 at cycle 0 -> out_valid at cycle 2, out_data=0x5555, out_sel=5.
- Back-to-back sel=0,16,30 on consecutive cycles -> outputs 0x0, 0x11110, 0x1FFFE on 3 consecutive cycles; in_ready stays 1.
- sel=31 with entry 31=0xFFFF_FFFF_FFFF_FFFF, ZERO_REG=1 -> out_data=0. Also wr_en=1, wr_addr=31 at acceptance -> still 0.
- sel=7 with wr_en=1, wr_addr=7, wr_data=0xDEAD_BEEF at acceptance -> out_data=0xDEAD_BEEF. Array entry 7 changed to 0x1 the cycle after -> output unchanged.
- out_ready=0 for 4 cycles with requests sel=1,2,3 offered -> two accepted, in_ready=0 afterwards, out_data=0x1111 held stable. Release -> 0x1111, 0x2222, 0x3333 in order, no loss.
- reset_n pulsed low while 2 requests are in flight -> out_valid=0 asynchronously; no stale output after release.

Source files
------------

// File: rtl/read_mux_pkg.sv
// Shared constants, stage-1 record layout and result-priority helper for the register-file read mux.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package read_mux_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_BANK  = 16;
    localparam int DEF_NBANK = (DEF_DEPTH + DEF_BANK - 1) / DEF_BANK;
    localparam int DEF_UP_W  = (DEF_NBANK > 1) ? $clog2(DEF_NBANK) : 1;

    typedef enum logic [1:0] {
        RES_ARRAY,
        RES_FWD,
        RES_ZERO
    } res_t;

    // Stage-1 record for the default geometry; the top builds the same layout from its parameters.
    typedef struct packed {
        logic [DEF_NBANK*DEF_WIDTH-1:0] bank;
        logic [DEF_UP_W-1:0]            hi;
        logic [$clog2(DEF_DEPTH)-1:0]   sel;
        logic                           zero;
        logic                           fwd;
        logic [DEF_WIDTH-1:0]           fwd_data;
    } s1_rec_t;

    // Hard zero beats a same-cycle write, which beats the stored array value.
    function automatic res_t res_pick(input logic zero, input logic fwd);
        if (zero)
            return RES_ZERO;
        else if (fwd)
            return RES_FWD;
        else
            return RES_ARRAY;
    endfunction

endpackage

// File: rtl/pipelined_read_mux_bank_mux.sv
// Combinational N:1 word select; out-of-range index yields zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no state.
module bank_mux #(
    parameter  int WIDTH = 64,
    parameter  int N     = 16,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*WIDTH-1:0] words,
    input  logic [SW-1:0]      idx,
    output logic [WIDTH-1:0]   word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i))
                word = words[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/pipelined_read_mux.sv
// Register-file read port: two-level banked DEPTH:1 select with write forwarding and optional hard-zero top entry.
// Latency: 2 cycles from acceptance to out_valid; 1 request per cycle.
// Backpressure: valid/ready; stalls hold both stages (max 2 in flight), in_ready is combinational from out_ready only.
module pipelined_read_mux
    import read_mux_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int BANK     = DEF_BANK,
    parameter  int ZERO_REG = 1,
    localparam int SEL_W    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DEPTH*WIDTH-1:0] data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel
);

    localparam int NBANK = (DEPTH + BANK - 1) / BANK;
    localparam int LBANK = $clog2(BANK);
    localparam int UP_W  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int EXT_W = LBANK + UP_W;
    localparam int PAD_W = NBANK * BANK * WIDTH;

    typedef struct packed {
        logic [NBANK*WIDTH-1:0] bank;
        logic [UP_W-1:0]        hi;
        logic [SEL_W-1:0]       sel;
        logic                   zero;
        logic                   fwd;
        logic [WIDTH-1:0]       fwd_data;
    } s1_t;

    s1_t                    s1, s1_next;
    logic                   s1_valid;
    logic                   s2_adv, s1_adv, accept;
    logic [EXT_W-1:0]       sel_ext;
    logic                   is_top, out_of_range;
    logic [PAD_W-1:0]       data_pad;
    logic [NBANK*WIDTH-1:0] bank_words;
    logic [WIDTH-1:0]       arr_word;
    logic [WIDTH-1:0]       result;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    // Widen sel so the bank/upper split works even when DEPTH is not a multiple of BANK.
    assign sel_ext      = EXT_W'(sel);
    assign is_top       = (ZERO_REG != 0) && (sel == SEL_W'(DEPTH - 1));
    assign out_of_range = 32'(sel) >= 32'(DEPTH);
    assign data_pad     = PAD_W'(data);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        bank_mux #(.WIDTH(WIDTH), .N(BANK)) u_bank (
            .words (data_pad[b*BANK*WIDTH +: BANK*WIDTH]),
            .idx   (sel_ext[LBANK-1:0]),
            .word  (bank_words[b*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        s1_next          = '0;
        s1_next.bank     = bank_words;
        s1_next.hi       = sel_ext[LBANK +: UP_W];
        s1_next.sel      = sel;
        s1_next.zero     = is_top || out_of_range;
        s1_next.fwd      = wr_en && (wr_addr == sel) && !is_top;
        s1_next.fwd_data = wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1       <= s1_next;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    bank_mux #(.WIDTH(WIDTH), .N(NBANK)) u_final (
        .words (s1.bank),
        .idx   (s1.hi),
        .word  (arr_word)
    );

    always_comb begin
        result = arr_word;
        case (res_pick(s1.zero, s1.fwd))
            RES_ZERO: result = '0;
            RES_FWD:  result = s1.fwd_data;
            default:  result = arr_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_sel   <= s1.sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_read_mux.sv
// Scoreboard bench for pipelined_read_mux: directed requests push expected words, a negedge monitor pops and compares.
module tb_pipelined_read_mux;

    localparam int W  = 64;
    localparam int D  = 32;
    localparam int SW = 5;

    logic              clk;
    logic              reset_n;
    logic [D*W-1:0]    data;
    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     sel;
    logic              wr_en;
    logic [SW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_sel;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    logic stall_done;

    pipelined_read_mux #(.WIDTH(W), .DEPTH(D), .BANK(16), .ZERO_REG(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one request; pushes its expected response at the cycle it is accepted.
    task automatic send(input logic [SW-1:0] s, input logic [W-1:0] e, input logic we,
                        input logic [SW-1:0] wa, input logic [W-1:0] wd, output int waits);
        bit done;
        done     = 0;
        waits    = 0;
        in_valid = 1'b1;
        sel      = s;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        while (!done && waits < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{e, s});
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: sel=%0d not accepted, got in_ready=0 required 1", s);
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(sbq.size()), 64'd0);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got data=%h sel=%0d required no output", out_data, out_sel);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_sel", 64'(out_sel), 64'(e.s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        clk        = 1'b0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        sel        = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        out_ready  = 1'b1;
        stall_done = 1'b0;
        for (int k = 0; k < D; k++)
            data[k*W +: W] = 64'(k) * 64'h1111;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic read and 2-cycle latency
        send(5'd5, 64'h5555, 1'b0, 5'd0, 64'd0, w);
        chk("t1_waits", 64'(w), 64'd0);
        @(negedge clk);
        chk("t1_valid_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_c2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back across both banks
        send(5'd0, 64'h0, 1'b0, 5'd0, 64'd0, w);
        chk("t2_waits0", 64'(w), 64'd0);
        send(5'd16, 64'h11110, 1'b0, 5'd0, 64'd0, w);
        chk("t2_waits1", 64'(w), 64'd0);
        send(5'd30, 64'h1FFFE, 1'b0, 5'd0, 64'd0, w);
        chk("t2_waits2", 64'(w), 64'd0);
        @(negedge clk);
        chk("t2_valid_b", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t2_valid_c", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t2_valid_end", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Hard-zero top entry, also when written in the same cycle
        data[31*W +: W] = '1;
        send(5'd31, 64'h0, 1'b0, 5'd0, 64'd0, w);
        send(5'd31, 64'h0, 1'b1, 5'd31, 64'h1234_5678_9ABC_DEF0, w);
        drain("t3_drain");

        // Forwarding, snapshot, and no forward without wr_en or on another address
        send(5'd7, 64'hDEAD_BEEF, 1'b1, 5'd7, 64'hDEAD_BEEF, w);
        data[7*W +: W] = 64'h1;
        send(5'd7, 64'h1, 1'b0, 5'd7, 64'hBAD0_BAD0, w);
        send(5'd9, 64'h9999, 1'b1, 5'd10, 64'hBAD1_BAD1, w);
        drain("t4_drain");

        // Output stall: two accepted, third blocked, head word held
        out_ready = 1'b0;
        fork
            begin : stall_feed
                int ws;
                send(5'd1, 64'h1111, 1'b0, 5'd0, 64'd0, ws);
                send(5'd2, 64'h2222, 1'b0, 5'd0, 64'd0, ws);
                send(5'd3, 64'h3333, 1'b0, 5'd0, 64'd0, ws);
                stall_done = 1'b1;
            end
        join_none
        repeat (4) @(negedge clk);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_hold_data", out_data, 64'h1111);
        chk("t5_hold_sel", 64'(out_sel), 64'd1);
        @(negedge clk);
        chk("t5_hold_data2", out_data, 64'h1111);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !stall_done; i++)
            @(posedge clk);
        chk("t5_feed_done", 64'(stall_done), 64'd1);
        drain("t5_no_loss");

        // Async reset with two requests in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(5'd4, 64'h4444, 1'b0, 5'd0, 64'd0, w);
        send(5'd6, 64'h6666, 1'b0, 5'd0, 64'd0, w);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(5'd3, 64'h3333, 1'b0, 5'd0, 64'd0, w);
        drain("t6_after_reset");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
